// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit path.
//   state_t   : arbiter FSM encoding (IDLE / SEND / RELEASE).
//   CLK_FREQ  : default system clock frequency in Hz, shared with uarttx.
//   BAUD_RATE : default line rate, shared with uarttx.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam int CLK_FREQ  = 50_000_000;
  localparam int BAUD_RATE = 115_200;

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker.
//   req    : request levels, one bit per requester.
//   ptr    : index that has the highest priority this round.
//   winner : first requesting index found searching ptr, ptr+1, ... (mod N_REQ).
//   valid  : high when any request is present (winner is meaningful).
module uart_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    winner,
  output logic             valid
);

  int          idx;
  logic [PW-1:0] idx_w;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    idx_w  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // Modulo without a divider: ptr + k never exceeds 2*N_REQ-2.
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_w = idx[PW-1:0];
      if (!valid && req[idx_w]) begin
        valid  = 1'b1;
        winner = idx_w;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one uarttx byte transmitter.
//   clk         : system clock (same clock as uarttx).
//   rst         : asynchronous active-low reset.
//   req         : per-requester request level.
//   req_data    : byte for requester i at [8*i+7:8*i].
//   grant       : one-hot owner of the transmitter, zero when free.
//   ack         : one-clk pulse to the owner when its frame completes.
//   timeout_err : one-clk pulse when the watchdog aborts a frame.
//   busy        : high whenever the FSM is not in IDLE.
//   tx_new_data : to uarttx.new_data.
//   tx_data     : to uarttx.tx_data.
//   tx_done     : from uarttx.doneTx (uclk domain, treated as asynchronous).
//   dbg_state   : current FSM state, for observation.
//
// Handshake: a requester raises req[i] with req_data stable and holds both
// until it sees ack[i] or timeout_err while granted; the byte is captured on
// the grant edge, so the requester may drop or change them after that edge
// without affecting the frame. Exactly one ack or timeout_err ends each grant.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   ack,
  output logic               timeout_err,
  output logic               busy,
  output logic               tx_new_data,
  output logic [7:0]         tx_data,
  input  logic               tx_done,
  output logic [1:0]         dbg_state
);

  localparam int            PW     = $clog2(N_REQ);
  localparam int            CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
  localparam logic [PW-1:0] LAST   = PW'(N_REQ - 1);

  // doneTx synchronizer plus one extra stage for rise detection.
  logic sync1, done_s, done_q;
  logic done_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b0;
      done_s <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sync1  <= tx_done;
      done_s <= sync1;
      done_q <= done_s;
    end
  end

  assign done_rise = done_s & ~done_q;

  logic [PW-1:0] pick;
  logic          pick_valid;
  logic [PW-1:0] ptr_q, ptr_d;

  uart_rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick),
    .valid  (pick_valid)
  );

  state_t        state_q, state_d;
  logic [PW-1:0] winner_q, winner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic          to_q, to_d;
  logic          nd_q, nd_d;
  logic [7:0]    data_q, data_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      winner_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      to_q     <= 1'b0;
      nd_q     <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      to_q     <= to_d;
      nd_q     <= nd_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    ack_d    = '0;
    to_d     = 1'b0;
    nd_d     = nd_q;
    data_d   = data_q;
    case (state_q)
      ST_IDLE: begin
        // A still-high done_s belongs to the previous frame; wait it out so
        // its level cannot be mistaken for completion of the next one.
        if (pick_valid && !done_s) begin
          winner_d = pick;
          grant_d  = N_REQ'(1) << pick;
          for (int i = 0; i < N_REQ; i++) begin
            if (pick == PW'(i)) data_d = req_data[8*i +: 8];
          end
          nd_d     = 1'b1;
          cnt_d    = '0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        cnt_d = cnt_q + 1'b1;
        // Completion has priority over the watchdog in the same cycle.
        if (done_rise) begin
          nd_d    = 1'b0;
          ack_d   = grant_q;
          state_d = ST_RELEASE;
        end else if (cnt_q == TO_VAL) begin
          nd_d    = 1'b0;
          to_d    = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Pointer moves past the winner on timeout too, so a stuck
        // requester cannot monopolise the transmitter.
        if (!done_s) begin
          grant_d = '0;
          ptr_d   = (winner_q == LAST) ? '0 : winner_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign grant       = grant_q;
  assign ack         = ack_q;
  assign timeout_err = to_q;
  assign tx_new_data = nd_q;
  assign tx_data     = data_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one `uarttx` byte transmitter among `N_REQ` requesters on the system clock. It grants one requester at a time and drives the transmitter's `new_data` and `tx_data`. It watches `doneTx`, acknowledges the requester, and recovers from a hung frame with a watchdog. It sits between the byte producers (command responders, debug printers) and the single UART pin.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 4096: clk cycles allowed in SEND before abort; counter width `$clog2(TIMEOUT+1)`.

Ports:
- `clk`  input  1  system clock; the same clock that feeds `uarttx`.
- `rst`  input  1  asynchronous, active-low reset.
- `req`  input  N_REQ  per-requester request level; held until `ack` or `timeout_err` for that requester.
- `req_data`  input  8*N_REQ  byte for requester i at bits `[8*i+7:8*i]`; stable while `req[i]` is high.
- `grant`  output  N_REQ  one-hot owner of the transmitter; all zero when free.
- `ack`  output  N_REQ  one-clk pulse to the owner on frame completion.
- `timeout_err`  output  1  one-clk pulse on watchdog abort.
- `busy`  output  1  high in any state other than IDLE.
- `tx_new_data`  output  1  drives `uarttx.new_data`.
- `tx_data`  output  8  drives `uarttx.tx_data`.
- `tx_done`  input  1  from `uarttx.doneTx`; generated in the `uclk` domain and treated as asynchronous.

## Operation
- `tx_done` passes through a 2-FF synchronizer to give `done_s`. `done_s` delayed by one cycle gives `done_q`. A rise is detected when `done_s & ~done_q`.
- Round-robin pointer `ptr` (0..N_REQ-1) resets to 0. The winner is the first `i` with `req[i]=1`, searching `ptr, ptr+1, …` modulo N_REQ.
- State machine: IDLE, SEND, RELEASE.
  - IDLE: if `|req` and `done_s==0`, then:
    - register the winner index, `grant` one-hot, `tx_data <= req_data[winner]` and `tx_new_data <= 1`;
    - go to SEND.
    - Otherwise stay in IDLE.
  - SEND: the watchdog counts up from 0.
    - On a `done_s` rise: `tx_new_data <= 0`, `ack[winner]` pulses, go to RELEASE.
    - Otherwise, if the count reaches `TIMEOUT`: `tx_new_data <= 0`, `timeout_err` pulses, no `ack`, go to RELEASE.
  - RELEASE: wait for `done_s==0`.
    - Then clear `grant`, set `ptr <= winner+1` (wrapping to 0 after N_REQ-1), go to IDLE.
    - `ptr` also advances after a timeout, so a faulty requester cannot starve the others.
- If a `done_s` rise and a timeout occur in the same cycle, the done rise wins: `ack` pulses and `timeout_err` does not.
- `req[winner]` dropping during SEND is ignored. The frame completes and `ack` still pulses.
- `req_data` changes after the grant cycle are ignored, because `tx_data` is registered.
- A requester that is still requesting after `ack` competes again. The pointer guarantees the others are served first.
- Reset values: `grant=0`, `ack=0`, `timeout_err=0`, `busy=0`, `tx_new_data=0`, `tx_data=8'h00`, `ptr=0`, state IDLE, synchronizer flops 0.
- Reset mid-frame returns all outputs to their reset values immediately. `uarttx` is reset by the same system reset.

## Timing
- `req` seen in IDLE gives `grant`, `tx_new_data` and `tx_data` on the next clk edge (latency 1).
- `tx_new_data` is held level until the done rise is detected. `uarttx` samples it on its next IDLE `uclk` edge.
- `ack` rises 3 clk after the `tx_done` rise (2 sync stages plus the edge register).
- `ack` is a single cycle wide. At most one `ack` or `timeout_err` is issued per grant.
- `tx_new_data` must fall before the next `uclk` edge, so `(clk_freq/baud_rate)/2 >= 4` is required.
- Minimum spacing between grants: RELEASE until `doneTx` falls, plus 1 clk in IDLE.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding `ST_IDLE=2'd0`, `ST_SEND=2'd1`, `ST_RELEASE=2'd2`;
  - the default `clk_freq` and `baud_rate` constants, shared with `uarttx`.
- Sub-module `uart_rr_pick`: combinational round-robin picker. Inputs `req` and `ptr`; outputs `winner` index and `valid`. The pick logic is unit-tested standalone.
- Top-level bench instantiates `uart_tx_arbiter` together with `uarttx`.

## Test plan
- Single requester: `req=4'b0001`, `req_data[7:0]=8'hA5` → `grant=0001`; the `tx` line shows start bit, then LSB-first `1,0,1,0,0,1,0,1`, then stop; one `ack[0]` pulse; `busy` returns to 0.
- All four requesting from reset with bytes `8'h11, 8'h22, 8'h33, 8'h44` → frames sent in order 0,1,2,3. With `req[0]` re-asserted after its ack, the next order is 1,2,3,0.
- `tx_done` tied low, `req=4'b0100` → `timeout_err` pulses exactly `TIMEOUT+1` clk after the grant; no `ack`; `grant` clears; `ptr=3`.
- `req[1]` dropped and `req_data` changed mid-SEND → the original byte is transmitted and `ack[1]` still pulses.
- `rst` asserted low mid-frame → within the same cycle `grant=0`, `tx_new_data=0`, `busy=0`. After release, a new request completes normally.
